// File: rtl/tetris_key_repeat_if.sv
// Command handshake between the key-repeat block and the game state machine.
//   cmd_valid : a command is pending (driven by the master)
//   cmd       : pending command code, 1..7 (driven by the master)
//   cmd_ready : consumer accepts the pending command (driven by the slave)
interface tetris_key_repeat_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_key_repeat.sv
// Turns a software-written HID keycode into discrete Tetris commands.
// LEFT/RIGHT use delayed auto-shift then auto-repeat, SOFT_DROP repeats
// without a delay phase, all other keys fire once per press. Commands are
// offered through a single-entry valid/ready slot.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   keycode    : HID keycode, 0x00 = no key
//   frame_tick : one-cycle pulse per video frame
//   cmd_if     : command slot (cmd_valid / cmd / cmd_ready)
//   dropped    : sticky, a command was lost because the slot was full
module tetris_key_repeat #(
  parameter int unsigned DAS_FRAMES  = 16,
  parameter int unsigned ARR_FRAMES  = 6,
  parameter int unsigned SOFT_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 keycode,
  input  logic                       frame_tick,
  tetris_key_repeat_if.master        cmd_if,
  output logic                       dropped
);

  // Class encoding doubles as the command code.
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_LEFT  = 3'd1,
    CLS_RIGHT = 3'd2,
    CLS_SOFT  = 3'd3,
    CLS_HARD  = 3'd4,
    CLS_CW    = 3'd5,
    CLS_CCW   = 3'd6,
    CLS_PAUSE = 3'd7
  } cls_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HOLD
  } state_t;

  localparam logic [5:0] DAS_CNT  = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_CNT  = 6'(ARR_FRAMES);
  localparam logic [5:0] SOFT_CNT = 6'(SOFT_FRAMES);

  logic [7:0] key_q, key_d;
  cls_t       cls_q, cls_d;
  cls_t       cls;
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [2:0] cmd_q, cmd_d;
  logic       dropped_q, dropped_d;
  logic       press;
  logic       emit;

  always_comb begin
    case (key_q)
      8'h04, 8'h50: cls = CLS_LEFT;
      8'h07, 8'h4F: cls = CLS_RIGHT;
      8'h16, 8'h51: cls = CLS_SOFT;
      8'h2C:        cls = CLS_HARD;
      8'h1A, 8'h52: cls = CLS_CW;
      8'h14:        cls = CLS_CCW;
      8'h13:        cls = CLS_PAUSE;
      default:      cls = CLS_NONE;
    endcase
  end

  assign press = (cls != cls_q) && (cls != CLS_NONE);
  assign key_d = keycode;
  assign cls_d = cls;

  // Key/repeat FSM. A press is checked before the tick so a coincident
  // frame_tick is swallowed and the repeat state restarts from scratch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (cls == CLS_NONE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (press) begin
      emit = 1'b1;
      case (cls)
        CLS_LEFT, CLS_RIGHT: begin
          state_d = ST_DELAY;
          cnt_d   = DAS_CNT;
        end
        CLS_SOFT: begin
          state_d = ST_REPEAT;
          cnt_d   = SOFT_CNT;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end else begin
      case (state_q)
        ST_DELAY, ST_REPEAT: begin
          if (frame_tick) begin
            if (cnt_q == 6'd1) begin
              emit    = 1'b1;
              state_d = ST_REPEAT;
              cnt_d   = (cls == CLS_SOFT) ? SOFT_CNT : ARR_CNT;
            end else begin
              cnt_d = cnt_q - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Single-entry command slot; an emission that cannot be stored is lost.
  always_comb begin
    valid_d   = valid_q;
    cmd_d     = cmd_q;
    dropped_d = dropped_q;
    if (emit) begin
      if (!valid_q || cmd_if.cmd_ready) begin
        valid_d = 1'b1;
        cmd_d   = cls;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && cmd_if.cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q     <= '0;
      cls_q     <= CLS_NONE;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      cmd_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      cls_q     <= cls_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      cmd_q     <= cmd_d;
      dropped_q <= dropped_d;
    end
  end

  assign cmd_if.cmd_valid = valid_q;
  assign cmd_if.cmd       = cmd_q;
  assign dropped          = dropped_q;

endmodule

// File: tb/tb_tetris_key_repeat.sv
// Directed bench for tetris_key_repeat with DAS=3, ARR=2, SOFT=1.
module tb_tetris_key_repeat;

  logic       clk;
  logic       reset_n;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       dropped;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [2:0]  acc_q[$];

  tetris_key_repeat_if cmd_if ();

  tetris_key_repeat #(
    .DAS_FRAMES (3),
    .ARR_FRAMES (2),
    .SOFT_FRAMES(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keycode   (keycode),
    .frame_tick(frame_tick),
    .cmd_if    (cmd_if.master),
    .dropped   (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted command; handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (reset_n && cmd_if.cmd_valid && cmd_if.cmd_ready)
      acc_q.push_back(cmd_if.cmd);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(2);
  endtask

  task automatic check_queue(input string tag, input int unsigned n, input logic [2:0] c);
    check({tag, "_count"}, acc_q.size(), n);
    foreach (acc_q[i]) check({tag, "_cmd"}, {29'd0, acc_q[i]}, {29'd0, c});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    keycode = 8'h00;
    frame_tick = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    step(3);
    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_cmd", cmd_if.cmd, 0);
    check("rst_dropped", dropped, 0);
    reset_n = 1'b1;
    step(2);

    // LEFT: press, then repeats on ticks 3, 5, 7, 9
    acc_q.delete();
    keycode = 8'h04;
    step(1);
    check("left_lat_early", cmd_if.cmd_valid, 0);
    step(1);
    check("left_press_valid", cmd_if.cmd_valid, 1);
    check("left_press_cmd", cmd_if.cmd, 1);
    step(1);
    check("left_press_clear", cmd_if.cmd_valid, 0);
    for (int unsigned i = 1; i <= 10; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      if (i == 2) check("left_tick2_quiet", cmd_if.cmd_valid, 0);
      if (i == 3) begin
        check("left_tick3_valid", cmd_if.cmd_valid, 1);
        check("left_tick3_cmd", cmd_if.cmd, 1);
      end
      if (i == 4) check("left_tick4_quiet", cmd_if.cmd_valid, 0);
      step(2);
    end
    keycode = 8'h00;
    step(3);
    check_queue("left", 5, 3'd1);
    check("left_dropped", dropped, 0);

    // SOFT_DROP: press, then every tick
    acc_q.delete();
    keycode = 8'h51;
    step(3);
    for (int unsigned i = 0; i < 4; i++) pulse_tick();
    keycode = 8'h00;
    step(3);
    check_queue("soft", 5, 3'd3);

    // HARD_DROP fires once per press
    acc_q.delete();
    keycode = 8'h2C;
    step(3);
    for (int unsigned i = 0; i < 20; i++) pulse_tick();
    keycode = 8'h00;
    step(3);
    keycode = 8'h2C;
    step(3);
    for (int unsigned i = 0; i < 2; i++) pulse_tick();
    keycode = 8'h00;
    step(3);
    check_queue("hard", 2, 3'd4);

    // Full slot: second press is lost and flagged
    cmd_if.cmd_ready = 1'b0;
    keycode = 8'h1A;
    step(3);
    check("full_valid", cmd_if.cmd_valid, 1);
    check("full_cmd_cw", cmd_if.cmd, 5);
    keycode = 8'h14;
    step(3);
    check("full_cmd_kept", cmd_if.cmd, 5);
    check("full_dropped", dropped, 1);
    cmd_if.cmd_ready = 1'b1;
    step(1);
    cmd_if.cmd_ready = 1'b0;
    check("full_drain", cmd_if.cmd_valid, 0);
    check("full_dropped_sticky", dropped, 1);
    keycode = 8'h00;
    cmd_if.cmd_ready = 1'b1;
    step(3);

    // RIGHT -> LEFT change coincident with the tick that would repeat RIGHT
    acc_q.delete();
    keycode = 8'h07;
    step(3);
    pulse_tick();
    pulse_tick();
    keycode = 8'h04;
    step(1);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    check("switch_valid", cmd_if.cmd_valid, 1);
    check("switch_cmd", cmd_if.cmd, 1);
    step(2);
    check("switch_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check("switch_first", acc_q[0], 2);
      check("switch_second", acc_q[1], 1);
    end
    pulse_tick();
    pulse_tick();
    check("switch_no_early_rep", acc_q.size(), 2);
    pulse_tick();
    check("switch_rep_count", acc_q.size(), 3);
    if (acc_q.size() == 3) check("switch_rep_cmd", acc_q[2], 1);

    // Asynchronous reset during REPEAT with a pending command
    cmd_if.cmd_ready = 1'b0;
    keycode = 8'h51;
    step(3);
    pulse_tick();
    check("pre_rst_valid", cmd_if.cmd_valid, 1);
    check("pre_rst_dropped", dropped, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", cmd_if.cmd_valid, 0);
    check("async_rst_dropped", dropped, 0);
    check("async_rst_cmd", cmd_if.cmd, 0);
    step(2);
    reset_n = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    step(2);
    check("post_rst_valid", cmd_if.cmd_valid, 1);
    check("post_rst_cmd", cmd_if.cmd, 3);
    keycode = 8'h00;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
